keypad_scan: RTL and testbench



---
 rtl/keypad_pkg.sv | 40 ++++
 rtl/keypad_sync.sv | 29 ++
 rtl/keypad_scan.sv | 218 +++++++++++++++++++++
 tb/tb_keypad_scan.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
//   state_e   : debounce FSM state encoding
//   frame_e   : per-frame scan result kind
//   frame_t   : frame result payload (kind + key code)
//   KEY_NONE  : key code presented when nothing has been confirmed
//   COL_RESET : column drive pattern out of reset (column 0 active)
package keypad_pkg;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_DEB_PRESS   = 2'd1,
        ST_PRESSED     = 2'd2,
        ST_DEB_RELEASE = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        FR_NONE  = 2'd0,
        FR_ONE   = 2'd1,
        FR_MULTI = 2'd2
    } frame_e;

    typedef struct packed {
        frame_e     kind;
        logic [3:0] code;
    } frame_t;

    localparam logic [3:0] KEY_NONE  = 4'h0;
    localparam logic [3:0] COL_RESET = 4'b1110;

    // Number of active-low rows in one column sample
    function automatic logic [2:0] count_low(input logic [3:0] r);
        logic [2:0] n;
        n = 3'd0;
        for (int i = 0; i < 4; i++) begin
            n = n + 3'(~r[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/keypad_sync.sv
// Two-flop synchroniser for asynchronous inputs; resets to all-ones (idle rows).
//   clk, rstN : clock, async active-low reset
//   d_i       : asynchronous input
//   q_o       : synchronised output
module keypad_sync #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            meta_q <= '1;
            sync_q <= '1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner with frame-level debounce and valid/ack key handoff.
//   clk, rstN : board clock, async active-low reset
//   row       : active-low keypad rows (asynchronous)
//   col       : active-low column drive, one bit low at a time
//   keyCode   : confirmed key code (row*4 + column)
//   keyValid  : keyCode holds an unacknowledged key
//   keyAck    : single-cycle consumer acknowledge
//   keyDown   : confirmed key is currently held
//   overrun   : sticky, a key was confirmed while keyValid was still set
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV   = 12000,
    parameter int unsigned DEB_FRAMES = 4
) (
    input  logic       clk,
    input  logic       rstN,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] keyCode,
    output logic       keyValid,
    input  logic       keyAck,
    output logic       keyDown,
    output logic       overrun
);

    localparam int unsigned   DW         = $clog2(SCAN_DIV);
    localparam int unsigned   MW         = $clog2(DEB_FRAMES + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [MW-1:0] MATCH_TGT  = MW'(DEB_FRAMES);

    logic [3:0]    row_s;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [3:0]    col_q, col_d;
    logic [1:0]    col_idx_q, col_idx_d;
    logic [1:0]    hits_q, hits_d;
    logic [3:0]    fcode_q, fcode_d;
    state_e        state_q, state_d;
    logic [MW-1:0] match_q, match_d, match_inc;
    logic [3:0]    cand_q, cand_d;
    logic [3:0]    key_code_q;
    logic          key_valid_q, key_down_q, overrun_q;

    logic          last_dwell_c, frame_end_c, confirm_c, one_cand_c;
    frame_t        frame_c;
    logic [2:0]    lows_c, hit_sum_c;
    logic [1:0]    cur_hits_c, cur_row_c;

    keypad_sync #(.WIDTH(4)) u_row_sync (
        .clk  (clk),
        .rstN (rstN),
        .d_i  (row),
        .q_o  (row_s)
    );

    // Column dwell timing and rotation
    always_comb begin
        last_dwell_c = (dwell_q == DWELL_LAST);
        frame_end_c  = last_dwell_c && (col_idx_q == 2'd3);
        dwell_d      = last_dwell_c ? '0 : dwell_q + DW'(1);
        col_d        = last_dwell_c ? {col_q[2:0], col_q[3]} : col_q;
        col_idx_d    = last_dwell_c ? col_idx_q + 2'd1 : col_idx_q;
    end

    // Accumulate key hits across the four columns; hit count saturates at 2
    always_comb begin
        cur_row_c = 2'd0;
        for (int r = 3; r >= 0; r--) begin
            if (!row_s[r]) cur_row_c = 2'(r);
        end
        lows_c     = count_low(row_s);
        cur_hits_c = (lows_c >= 3'd2) ? 2'd2 : lows_c[1:0];
        hit_sum_c  = {1'b0, hits_q} + {1'b0, cur_hits_c};

        frame_c.code = (hits_q != 2'd0) ? fcode_q : {cur_row_c, col_idx_q};
        if (hit_sum_c == 3'd0)      frame_c.kind = FR_NONE;
        else if (hit_sum_c == 3'd1) frame_c.kind = FR_ONE;
        else                        frame_c.kind = FR_MULTI;

        hits_d  = hits_q;
        fcode_d = fcode_q;
        if (frame_end_c) begin
            hits_d  = 2'd0;
            fcode_d = KEY_NONE;
        end else if (last_dwell_c) begin
            hits_d  = (hit_sum_c >= 3'd2) ? 2'd2 : hit_sum_c[1:0];
            fcode_d = frame_c.code;
        end
    end

    // Debounce FSM, advanced once per frame
    always_comb begin
        state_d    = state_q;
        match_d    = match_q;
        cand_d     = cand_q;
        confirm_c  = 1'b0;
        match_inc  = (match_q == MATCH_TGT) ? match_q : match_q + MW'(1);
        one_cand_c = (frame_c.kind == FR_ONE) && (frame_c.code == cand_q);

        if (frame_end_c) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (frame_c.kind == FR_ONE) begin
                        cand_d = frame_c.code;
                        if (DEB_FRAMES == 1) begin
                            confirm_c = 1'b1;
                            state_d   = ST_PRESSED;
                            match_d   = '0;
                        end else begin
                            state_d = ST_DEB_PRESS;
                            match_d = MW'(1);
                        end
                    end
                end
                ST_DEB_PRESS: begin
                    if (one_cand_c) begin
                        match_d = match_inc;
                        if (match_inc == MATCH_TGT) begin
                            confirm_c = 1'b1;
                            state_d   = ST_PRESSED;
                            match_d   = '0;
                        end
                    end else begin
                        state_d = ST_IDLE;
                        match_d = '0;
                    end
                end
                ST_PRESSED: begin
                    // A different single key while held is ignored
                    if (frame_c.kind != FR_ONE) begin
                        if (DEB_FRAMES == 1) begin
                            state_d = ST_IDLE;
                            match_d = '0;
                        end else begin
                            state_d = ST_DEB_RELEASE;
                            match_d = MW'(1);
                        end
                    end
                end
                ST_DEB_RELEASE: begin
                    if (frame_c.kind != FR_ONE) begin
                        match_d = match_inc;
                        if (match_inc == MATCH_TGT) begin
                            state_d = ST_IDLE;
                            match_d = '0;
                        end
                    end else if (one_cand_c) begin
                        state_d = ST_PRESSED;
                        match_d = '0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    match_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q <= ST_IDLE;
            match_q <= '0;
            cand_q  <= KEY_NONE;
        end else begin
            state_q <= state_d;
            match_q <= match_d;
            cand_q  <= cand_d;
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            dwell_q   <= '0;
            col_q     <= COL_RESET;
            col_idx_q <= 2'd0;
            hits_q    <= 2'd0;
            fcode_q   <= KEY_NONE;
        end else begin
            dwell_q   <= dwell_d;
            col_q     <= col_d;
            col_idx_q <= col_idx_d;
            hits_q    <= hits_d;
            fcode_q   <= fcode_d;
        end
    end

    // Key handoff: a confirm accompanied by an ack replaces the key and clears overrun
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            key_code_q  <= KEY_NONE;
            key_valid_q <= 1'b0;
            key_down_q  <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            key_down_q <= (state_d == ST_PRESSED) || (state_d == ST_DEB_RELEASE);
            if (confirm_c) begin
                if (!key_valid_q || keyAck) begin
                    key_code_q  <= cand_q;
                    key_valid_q <= 1'b1;
                    overrun_q   <= 1'b0;
                end else begin
                    overrun_q <= 1'b1;
                end
            end else if (keyAck && key_valid_q) begin
                key_valid_q <= 1'b0;
                overrun_q   <= 1'b0;
            end
        end
    end

    assign col      = col_q;
    assign keyCode  = key_code_q;
    assign keyValid = key_valid_q;
    assign keyDown  = key_down_q;
    assign overrun  = overrun_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan: a simulated key matrix, a frame-level reference model
// checked every cycle, and directed scenarios with literal expectations.
`timescale 1ns/1ps
module tb_keypad_scan;

    localparam int unsigned SCAN_DIV   = 4;
    localparam int unsigned DEB_FRAMES = 2;
    localparam int unsigned FRAME      = 4 * SCAN_DIV;

    logic        clk = 1'b0;
    logic        rstN;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [3:0]  keyCode;
    logic        keyValid;
    logic        keyAck;
    logic        keyDown;
    logic        overrun;
    logic [15:0] keys;   // bit k set = key k pressed

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    keypad_scan #(
        .SCAN_DIV   (SCAN_DIV),
        .DEB_FRAMES (DEB_FRAMES)
    ) dut (
        .clk      (clk),
        .rstN     (rstN),
        .row      (row),
        .col      (col),
        .keyCode  (keyCode),
        .keyValid (keyValid),
        .keyAck   (keyAck),
        .keyDown  (keyDown),
        .overrun  (overrun)
    );

    // Passive key matrix: a pressed key pulls its row low while its column is driven
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++) begin
            row[r] = ~|(keys[r*4 +: 4] & ~col);
        end
    end

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: cycle index since reset, key set seen per frame, debounce by frame counts
    int          n        = 0;
    logic [15:0] h1       = '0;
    logic [15:0] h2       = '0;
    logic [15:0] seen     = '0;
    logic        held     = 1'b0;
    logic        pressing = 1'b0;
    int          streak   = 0;
    int          rel      = 0;
    logic [3:0]  cand     = '0;
    logic [3:0]  e_code   = '0;
    logic        e_valid  = 1'b0;
    logic        e_down   = 1'b0;
    logic        e_over   = 1'b0;

    always @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            n = 0; h1 = '0; h2 = '0; seen = '0;
            held = 1'b0; pressing = 1'b0; streak = 0; rel = 0; cand = '0;
            e_code = '0; e_valid = 1'b0; e_down = 1'b0; e_over = 1'b0;
        end else begin
            int   c;
            int   nkeys;
            int   kidx;
            logic one;
            logic conf;
            conf = 1'b0;
            c    = (n / SCAN_DIV) % 4;
            // rows reach the scanner two cycles late
            if ((n % SCAN_DIV) == SCAN_DIV - 1) begin
                for (int r = 0; r < 4; r++) begin
                    if (h2[r*4 + c]) seen[r*4 + c] = 1'b1;
                end
            end
            if ((n % FRAME) == FRAME - 1) begin
                nkeys = $countones(seen);
                kidx  = 0;
                for (int k = 0; k < 16; k++) begin
                    if (seen[k]) kidx = k;
                end
                one = (nkeys == 1);
                if (held) begin
                    if (one && 4'(kidx) == cand) rel = 0;
                    else if (!one) begin
                        rel++;
                        if (rel >= DEB_FRAMES) begin
                            held = 1'b0;
                            rel  = 0;
                        end
                    end
                end else if (pressing) begin
                    if (one && 4'(kidx) == cand) begin
                        streak++;
                        if (streak >= DEB_FRAMES) begin
                            conf = 1'b1; held = 1'b1; pressing = 1'b0; rel = 0;
                        end
                    end else begin
                        pressing = 1'b0;
                    end
                end else if (one) begin
                    cand   = 4'(kidx);
                    streak = 1;
                    if (streak >= DEB_FRAMES) begin
                        conf = 1'b1; held = 1'b1; rel = 0;
                    end else begin
                        pressing = 1'b1;
                    end
                end
                seen = '0;
            end
            if (conf) begin
                if (!e_valid || keyAck) begin
                    e_code = cand; e_valid = 1'b1; e_over = 1'b0;
                end else begin
                    e_over = 1'b1;
                end
            end else if (keyAck && e_valid) begin
                e_valid = 1'b0; e_over = 1'b0;
            end
            e_down = held;
            h2 = h1;
            h1 = keys;
            n++;
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (rstN === 1'b1) begin
            logic [3:0] ec;
            ec = 4'b0001 << ((n / SCAN_DIV) % 4);
            chk("col", col, ~ec);
            chk("keyCode", keyCode, e_code);
            chk("keyValid", {3'b0, keyValid}, {3'b0, e_valid});
            chk("keyDown", {3'b0, keyDown}, {3'b0, e_down});
            chk("overrun", {3'b0, overrun}, {3'b0, e_over});
        end
    end

    task automatic tick(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic align_frame();
        int guard;
        guard = 0;
        while ((n % FRAME) != 0 && guard < 2 * FRAME) begin
            tick(1);
            guard++;
        end
        if ((n % FRAME) != 0) begin
            checks++;
            errors++;
            $display("FAIL align: frame phase %0d expected 0", n % FRAME);
        end
    endtask

    task automatic ack_pulse();
        keyAck = 1'b1;
        tick(1);
        keyAck = 1'b0;
    endtask

    initial begin
        rstN   = 1'b0;
        keyAck = 1'b0;
        keys   = '0;

        // Reset with rows toggling
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            keys = (i % 2 == 1) ? 16'hFFFF : 16'h0000;
        end
        chk("rst col", col, 4'b1110);
        chk("rst keyCode", keyCode, 4'h0);
        chk("rst keyValid", {3'b0, keyValid}, 4'h0);
        chk("rst keyDown", {3'b0, keyDown}, 4'h0);
        chk("rst overrun", {3'b0, overrun}, 4'h0);
        keys = '0;
        @(posedge clk);
        #1;
        rstN = 1'b1;

        // Column rotation every SCAN_DIV clocks
        chk("rot0", col, 4'b1110);
        tick(4); chk("rot1", col, 4'b1101);
        tick(4); chk("rot2", col, 4'b1011);
        tick(4); chk("rot3", col, 4'b0111);
        tick(4); chk("rot4", col, 4'b1110);

        // Clean press of key 9 (row2/col1)
        align_frame();
        keys = 16'h0200;
        tick(5 * FRAME);
        chk("press9 code", keyCode, 4'h9);
        chk("press9 valid", {3'b0, keyValid}, 4'h1);
        chk("press9 down", {3'b0, keyDown}, 4'h1);
        ack_pulse();
        chk("ack9 valid", {3'b0, keyValid}, 4'h0);
        chk("ack9 down", {3'b0, keyDown}, 4'h1);
        keys = '0;
        tick(3 * FRAME);
        chk("rel9 down", {3'b0, keyDown}, 4'h0);

        // Bounce: key 0 in a single frame only
        align_frame();
        keys = 16'h0001;
        tick(FRAME);
        keys = '0;
        tick(2 * FRAME);
        chk("bounce valid", {3'b0, keyValid}, 4'h0);
        chk("bounce down", {3'b0, keyDown}, 4'h0);
        align_frame();
        keys = 16'h0001;
        tick(3 * FRAME);
        chk("key0 code", keyCode, 4'h0);
        chk("key0 valid", {3'b0, keyValid}, 4'h1);
        keys = '0;
        tick(3 * FRAME);
        ack_pulse();

        // Ghost: keys 5 and 6 together, then 5 alone
        align_frame();
        keys = 16'h0060;
        tick(4 * FRAME);
        chk("ghost valid", {3'b0, keyValid}, 4'h0);
        chk("ghost down", {3'b0, keyDown}, 4'h0);
        keys = 16'h0020;
        tick(2 * FRAME - 1);
        chk("key5 early valid", {3'b0, keyValid}, 4'h0);
        tick(1);
        chk("key5 valid", {3'b0, keyValid}, 4'h1);
        chk("key5 code", keyCode, 4'h5);
        keys = '0;
        tick(3 * FRAME);
        ack_pulse();

        // Overrun: key 3 left unacknowledged, then key 0xC
        align_frame();
        keys = 16'h0008;
        tick(3 * FRAME);
        keys = '0;
        tick(3 * FRAME);
        chk("key3 code", keyCode, 4'h3);
        chk("key3 valid", {3'b0, keyValid}, 4'h1);
        keys = 16'h1000;
        tick(3 * FRAME);
        chk("ovr code", keyCode, 4'h3);
        chk("ovr flag", {3'b0, overrun}, 4'h1);
        chk("ovr valid", {3'b0, keyValid}, 4'h1);
        keys = '0;
        tick(3 * FRAME);

        // Ack landing exactly on the confirm cycle
        align_frame();
        keys = 16'h1000;
        tick(2 * FRAME - 1);
        ack_pulse();
        chk("ackcf code", keyCode, 4'hC);
        chk("ackcf valid", {3'b0, keyValid}, 4'h1);
        chk("ackcf overrun", {3'b0, overrun}, 4'h0);
        keys = '0;
        tick(3 * FRAME);

        // Reset during debounce of key 0xF
        align_frame();
        keys = 16'h8000;
        tick(FRAME + 4);
        rstN = 1'b0;
        #1;
        chk("mrst col", col, 4'b1110);
        chk("mrst code", keyCode, 4'h0);
        chk("mrst valid", {3'b0, keyValid}, 4'h0);
        chk("mrst down", {3'b0, keyDown}, 4'h0);
        chk("mrst overrun", {3'b0, overrun}, 4'h0);
        tick(2);
        rstN = 1'b1;
        tick(2 * FRAME - 1);
        chk("keyF early valid", {3'b0, keyValid}, 4'h0);
        tick(1);
        chk("keyF valid", {3'b0, keyValid}, 4'h1);
        chk("keyF code", keyCode, 4'hF);
        keys = '0;
        tick(2 * FRAME);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
